// File: rtl/pipo_arb_pkg.sv
// Shared types and helpers for the pipo load arbiter.
// The LOCKED state is reachable only when PIPO_ARB_BURST_EN is defined.
package pipo_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pipo_rr_picker.sv
// Combinational round-robin picker: first valid index after ptr, with wrap.
// Produces a one-hot grant plus the matching binary index.
module pipo_rr_picker
   import pipo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]          valid,
   input  logic [idx_w(NUM_REQ)-1:0]   ptr,
   output logic [NUM_REQ-1:0]          grant,
   output logic [idx_w(NUM_REQ)-1:0]   idx
);

   localparam int IW = idx_w(NUM_REQ);

   int cand;

   // Walk from the farthest offset down so the nearest valid one overwrites last.
   always_comb begin
      grant = '0;
      idx   = '0;
      cand  = 0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = (int'(ptr) + k) % NUM_REQ;
         if (valid[cand]) begin
            grant       = '0;
            grant[cand] = 1'b1;
            idx         = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter sharing one pipo register between NUM_REQ producers.
// Optional burst locking is compiled in with PIPO_ARB_BURST_EN.
module pipo_load_arbiter
   import pipo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_ones,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
`ifdef PIPO_ARB_BURST_EN
   input  logic [NUM_REQ-1:0]            req_lock,
`endif
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          pipo_enable,
   output logic                          pipo_set_all_ones,
   output logic [DATA_WIDTH-1:0]         pipo_data_in,
   output logic [idx_w(NUM_REQ)-1:0]     owner
);

   localparam int IW = idx_w(NUM_REQ);
   localparam logic [IW-1:0] PTR_RST = IW'(NUM_REQ - 1);

   state_t                state_q, state_d;
   logic [IW-1:0]         ptr_q, ptr_d;
   logic                  ones_q, ones_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [IW-1:0]         owner_q, owner_d;

   logic [NUM_REQ-1:0]    rr_grant;
   logic [IW-1:0]         rr_idx;
   logic [IW-1:0]         win_idx;
   logic                  accept;

`ifdef PIPO_ARB_BURST_EN
   localparam int CW = idx_w(MAX_BURST + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   int            new_cnt;
`endif

   pipo_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .valid (req_valid),
      .ptr   (ptr_q),
      .grant (rr_grant),
      .idx   (rr_idx)
   );

   // State register plus issue-stage registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= PTR_RST;
         ones_q  <= 1'b0;
         data_q  <= '0;
         owner_q <= '0;
`ifdef PIPO_ARB_BURST_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         ones_q  <= ones_d;
         data_q  <= data_d;
         owner_q <= owner_d;
`ifdef PIPO_ARB_BURST_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   // Grant: a locked owner with valid held bypasses round-robin.
   always_comb begin
      req_ready = rr_grant;
      win_idx   = rr_idx;
`ifdef PIPO_ARB_BURST_EN
      if (state_q == LOCKED && req_valid[owner_q]) begin
         req_ready          = '0;
         req_ready[owner_q] = 1'b1;
         win_idx            = owner_q;
      end
`endif
      if (reset)
         req_ready = '0;
   end

   assign accept = |(req_valid & req_ready);

   always_comb begin
      state_d = IDLE;
`ifdef PIPO_ARB_BURST_EN
      cnt_d   = '0;
      new_cnt = 0;
`endif
      if (accept) begin
         state_d = ISSUE;
`ifdef PIPO_ARB_BURST_EN
         new_cnt = (state_q == LOCKED && win_idx == owner_q) ? int'(cnt_q) + 1 : 1;
         // Reaching MAX_BURST falls back to ISSUE; pointer = w lets the next index win.
         if (req_lock[win_idx] && new_cnt < MAX_BURST) begin
            state_d = LOCKED;
            cnt_d   = CW'(new_cnt);
         end
`endif
      end
   end

   always_comb begin
      ptr_d   = ptr_q;
      ones_d  = 1'b0;
      data_d  = data_q;
      owner_d = owner_q;
      if (accept) begin
         ptr_d   = win_idx;
         ones_d  = req_ones[win_idx];
         data_d  = req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
         owner_d = win_idx;
      end
   end

   assign pipo_enable       = (state_q != IDLE);
   assign pipo_set_all_ones = ones_q;
   assign pipo_data_in      = data_q;
   assign owner             = owner_q;

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Directed bench for pipo_load_arbiter (NUM_REQ=4, DATA_WIDTH=8).
// Burst-lock steps are included when PIPO_ARB_BURST_EN is defined.
module tb_pipo_load_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int MB = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [NR-1:0]     req_valid = '0;
   logic [NR-1:0]     req_ones = '0;
   logic [NR*DW-1:0]  req_data = '0;
`ifdef PIPO_ARB_BURST_EN
   logic [NR-1:0]     req_lock = '0;
`endif
   logic [NR-1:0]     req_ready;
   logic              pipo_enable;
   logic              pipo_set_all_ones;
   logic [DW-1:0]     pipo_data_in;
   logic [1:0]        owner;
   logic [DW-1:0]     reg_m;

   int n_chk = 0;
   int n_fail = 0;

   pipo_load_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
      .clk               (clk),
      .reset             (reset),
      .req_valid         (req_valid),
      .req_ones          (req_ones),
      .req_data          (req_data),
`ifdef PIPO_ARB_BURST_EN
      .req_lock          (req_lock),
`endif
      .req_ready         (req_ready),
      .pipo_enable       (pipo_enable),
      .pipo_set_all_ones (pipo_set_all_ones),
      .pipo_data_in      (pipo_data_in),
      .owner             (owner)
   );

   always #5 clk = ~clk;

   // Downstream pipo register: set_all_ones wins over data_in.
   always @(posedge clk) begin
      if (reset)
         reg_m <= '0;
      else if (pipo_enable)
         reg_m <= pipo_set_all_ones ? 8'hFF : pipo_data_in;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_inc_data(input logic [7:0] base);
      for (int i = 0; i < NR; i++)
         req_data[i*DW +: DW] = base + 8'(i);
   endtask

   initial begin
      logic [NR-1:0] exp_rdy;
      logic [1:0]    exp_own;

      // Reset state
      tick();
      tick();
      chk("rst_enable", 32'(pipo_enable), 32'd0);
      chk("rst_ones", 32'(pipo_set_all_ones), 32'd0);
      chk("rst_data", 32'(pipo_data_in), 32'd0);
      chk("rst_owner", 32'(owner), 32'd0);
      req_valid = 4'b0001;
      req_data[0 +: DW] = 8'hA5;
      #1;
      chk("rst_ready", 32'(req_ready), 32'd0);
      tick();

      // 1: first write after reset release goes to index 0
      reset = 1'b0;
      #1;
      chk("t1_ready", 32'(req_ready), 32'b0001);
      tick();
      chk("t1_enable", 32'(pipo_enable), 32'd1);
      chk("t1_data", 32'(pipo_data_in), 32'hA5);
      chk("t1_owner", 32'(owner), 32'd0);
      chk("t1_ones", 32'(pipo_set_all_ones), 32'd0);

      // 5: write 3C from index 3, then three idle cycles
      req_valid = 4'b1000;
      req_data[3*DW +: DW] = 8'h3C;
      #1;
      chk("t5_ready", 32'(req_ready), 32'b1000);
      tick();
      chk("t5_data_wr", 32'(pipo_data_in), 32'h3C);
      req_valid = '0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("t5_ready_idle", 32'(req_ready), 32'd0);
         tick();
         chk("t5_enable", 32'(pipo_enable), 32'd0);
         chk("t5_ones", 32'(pipo_set_all_ones), 32'd0);
         chk("t5_data_hold", 32'(pipo_data_in), 32'h3C);
         chk("t5_owner_hold", 32'(owner), 32'd3);
      end
      chk("t5_reg", 32'(reg_m), 32'h3C);

      // 2: all valid rotates 0,1,2,3,0 with enable every cycle
      req_valid = 4'b1111;
      load_inc_data(8'h10);
      for (int k = 0; k < 5; k++) begin
         exp_rdy = 4'b0001 << (k % 4);
         exp_own = 2'(k % 4);
         #1;
         chk("t2_ready", 32'(req_ready), 32'(exp_rdy));
         tick();
         chk("t2_enable", 32'(pipo_enable), 32'd1);
         chk("t2_data", 32'(pipo_data_in), 32'h10 + 32'(exp_own));
         chk("t2_owner", 32'(owner), 32'(exp_own));
      end
      req_valid = '0;

      // 3: all-ones request from index 2
      req_valid = 4'b0100;
      req_ones = 4'b0100;
      req_data = '0;
      #1;
      chk("t3_ready", 32'(req_ready), 32'b0100);
      tick();
      chk("t3_enable", 32'(pipo_enable), 32'd1);
      chk("t3_ones", 32'(pipo_set_all_ones), 32'd1);
      chk("t3_owner", 32'(owner), 32'd2);
      chk("t3_data", 32'(pipo_data_in), 32'h00);
      req_valid = '0;
      req_ones = '0;
      tick();
      chk("t3_reg_ff", 32'(reg_m), 32'hFF);
      chk("t3_ones_clr", 32'(pipo_set_all_ones), 32'd0);
      chk("t3_enable_clr", 32'(pipo_enable), 32'd0);

      // 4: reset in the cycle after an accept
      req_valid = 4'b1111;
      load_inc_data(8'h10);
      #1;
      chk("t4_ready_pre", 32'(req_ready), 32'b1000);
      tick();
      reset = 1'b1;
      #1;
      chk("t4_ready_rst", 32'(req_ready), 32'd0);
      chk("t4_enable_acc", 32'(pipo_enable), 32'd1);
      chk("t4_data_acc", 32'(pipo_data_in), 32'h13);
      tick();
      chk("t4_enable_drop", 32'(pipo_enable), 32'd0);
      chk("t4_owner_rst", 32'(owner), 32'd0);
      chk("t4_ready_rst2", 32'(req_ready), 32'd0);
      reset = 1'b0;
      #1;
      chk("t4_ready_post", 32'(req_ready), 32'b0001);
      tick();
      chk("t4_owner_post", 32'(owner), 32'd0);
      chk("t4_data_post", 32'(pipo_data_in), 32'h10);
      req_valid = '0;
      #1;
      chk("t4_ready_none", 32'(req_ready), 32'd0);

`ifdef PIPO_ARB_BURST_EN
      // 6: index 0 locks for MAX_BURST beats, then index 1, then 0 again
      reset = 1'b1;
      tick();
      reset = 1'b0;
      req_valid = 4'b0011;
      req_lock = 4'b0001;
      req_data[0 +: DW] = 8'hB0;
      req_data[1*DW +: DW] = 8'hB1;
      for (int k = 0; k < 6; k++) begin
         exp_own = (k == 4) ? 2'd1 : 2'd0;
         exp_rdy = 4'b0001 << exp_own;
         #1;
         chk("t6_ready", 32'(req_ready), 32'(exp_rdy));
         tick();
         chk("t6_owner", 32'(owner), 32'(exp_own));
      end
      req_valid = '0;
      req_lock = '0;
`endif

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
